seg_scan_display: RTL and testbench

Six-digit multiplexed seven-segment display driver. Consumes the six 6-bit character codes produced by the prompt/selection blocks (`Seg1`..`Seg6`), decodes each code to a glyph, and time-multiplexes the glyphs onto a common segment bus with one-hot digit enables. Captured codes take effect only at scan boundaries, so the display never shows a partly updated frame. Sits between the menu/prompt logic and the board's 6-digit display pins.

---
 rtl/seg_scan_display_if.sv | 21 ++
 rtl/seg_scan_display.sv | 139 +++++++++++++
 tb/tb_seg_scan_display.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/seg_scan_display_if.sv
// Bus between the prompt/menu logic and the six-digit display driver.
// Inputs are the character codes and masks; outputs are the pin-level display signals.
interface seg_scan_display_if;
  logic       load;
  logic [5:0] Seg1, Seg2, Seg3, Seg4, Seg5, Seg6;
  logic [5:0] dp_in;
  logic [5:0] blink_mask;
  logic [7:0] seg_out;
  logic [5:0] an;
  logic       scan_start;

  modport master (
    output load, Seg1, Seg2, Seg3, Seg4, Seg5, Seg6, dp_in, blink_mask,
    input  seg_out, an, scan_start
  );

  modport slave (
    input  load, Seg1, Seg2, Seg3, Seg4, Seg5, Seg6, dp_in, blink_mask,
    output seg_out, an, scan_start
  );
endinterface

// File: rtl/seg_scan_display.sv
// Six-digit multiplexed seven-segment driver with double-buffered codes,
// per-slot ghost blanking and per-digit blink.
module seg_scan_display #(
  parameter int CLK_DIV     = 50000,
  parameter int BLANK_CYC   = 500,
  parameter int BLINK_SCANS = 83,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic               clk,
  input  logic               rst,
  seg_scan_display_if.slave  bus
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_V = CW'(BLANK_CYC);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_SCANS - 1);
  localparam logic SEG_INV = (SEG_ACT_LOW != 0);
  localparam logic AN_INV  = (AN_ACT_LOW != 0);

  function automatic logic [6:0] glyph(input logic [5:0] c);
    case (c)
      6'd0:  glyph = 7'h3F;  6'd1:  glyph = 7'h06;  6'd2:  glyph = 7'h5B;
      6'd3:  glyph = 7'h4F;  6'd4:  glyph = 7'h66;  6'd5:  glyph = 7'h6D;
      6'd6:  glyph = 7'h7D;  6'd7:  glyph = 7'h07;  6'd8:  glyph = 7'h7F;
      6'd9:  glyph = 7'h6F;  6'd10: glyph = 7'h77;  6'd11: glyph = 7'h7C;
      6'd12: glyph = 7'h39;  6'd13: glyph = 7'h5E;  6'd14: glyph = 7'h79;
      6'd15: glyph = 7'h71;  6'd16: glyph = 7'h3D;  6'd17: glyph = 7'h76;
      6'd18: glyph = 7'h30;  6'd19: glyph = 7'h1E;  6'd20: glyph = 7'h75;
      6'd21: glyph = 7'h38;  6'd22: glyph = 7'h37;  6'd23: glyph = 7'h54;
      6'd24: glyph = 7'h5C;  6'd25: glyph = 7'h73;  6'd26: glyph = 7'h67;
      6'd27: glyph = 7'h50;  6'd28: glyph = 7'h6D;  6'd29: glyph = 7'h78;
      6'd30: glyph = 7'h3E;  6'd31: glyph = 7'h1C;  6'd32: glyph = 7'h2A;
      6'd33: glyph = 7'h76;  6'd34: glyph = 7'h6E;  6'd35: glyph = 7'h5B;
      6'd36: glyph = 7'h40;  6'd37: glyph = 7'h08;
      default: glyph = 7'h00;
    endcase
  endfunction

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      dig_q, dig_d;
  logic [BW-1:0]   blk_q, blk_d;
  logic            phase_q, phase_d;
  logic            upd_q, upd_d;
  logic [5:0][5:0] pcode_q, pcode_d, acode_q, acode_d;
  logic [5:0]      pdp_q, pdp_d, adp_q, adp_d;
  logic [5:0]      pblk_q, pblk_d, ablk_q, ablk_d;
  logic [7:0]      seg_q, seg_d;
  logic [5:0]      an_q, an_d;
  logic            ss_q, ss_d;
  logic            wrap, bnd;

  always_comb begin
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    blk_d   = blk_q;
    phase_d = phase_q;
    upd_d   = upd_q;
    pcode_d = pcode_q;
    pdp_d   = pdp_q;
    pblk_d  = pblk_q;
    acode_d = acode_q;
    adp_d   = adp_q;
    ablk_d  = ablk_q;

    wrap  = (cnt_q == CNT_MAX);
    bnd   = wrap && (dig_q == 3'd5);
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    if (wrap) dig_d = (dig_q == 3'd5) ? 3'd0 : dig_q + 3'd1;

    if (bnd) begin
      blk_d = (blk_q == BLK_MAX) ? '0 : blk_q + BW'(1);
      if (blk_q == BLK_MAX) phase_d = ~phase_q;
      if (upd_q) begin
        acode_d = pcode_q;
        adp_d   = pdp_q;
        ablk_d  = pblk_q;
      end
      upd_d = 1'b0;
    end

    // A capture on the boundary edge still lands in pending and stays queued.
    if (bus.load) begin
      pcode_d = {bus.Seg6, bus.Seg5, bus.Seg4, bus.Seg3, bus.Seg2, bus.Seg1};
      pdp_d   = bus.dp_in;
      pblk_d  = bus.blink_mask;
      upd_d   = 1'b1;
    end

    an_d  = '0;
    seg_d = '0;
    if (cnt_q >= BLANK_V) begin
      an_d = 6'b1 << dig_q;
      if (!(ablk_q[dig_q] && phase_q))
        seg_d = {adp_q[dig_q], glyph(acode_q[dig_q])};
    end
    ss_d = (cnt_q == '0) && (dig_q == 3'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      dig_q   <= '0;
      blk_q   <= '0;
      phase_q <= 1'b0;
      upd_q   <= 1'b0;
      pcode_q <= {6{6'd63}};
      acode_q <= {6{6'd63}};
      pdp_q   <= '0;
      adp_q   <= '0;
      pblk_q  <= '0;
      ablk_q  <= '0;
      seg_q   <= '0;
      an_q    <= '0;
      ss_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      blk_q   <= blk_d;
      phase_q <= phase_d;
      upd_q   <= upd_d;
      pcode_q <= pcode_d;
      acode_q <= acode_d;
      pdp_q   <= pdp_d;
      adp_q   <= adp_d;
      pblk_q  <= pblk_d;
      ablk_q  <= ablk_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      ss_q    <= ss_d;
    end
  end

  // Registers hold active-high values; pin polarity is a fixed inversion.
  assign bus.seg_out    = seg_q ^ {8{SEG_INV}};
  assign bus.an         = an_q ^ {6{AN_INV}};
  assign bus.scan_start = ss_q;
endmodule

// File: tb/tb_seg_scan_display.sv
// Randomized bench for seg_scan_display against a time-indexed reference model.
module tb_seg_scan_display;
  localparam int CD = 4, BL = 1, BS = 2;
  localparam int SCAN = 6 * CD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_display_if bus ();

  seg_scan_display #(
    .CLK_DIV(CD), .BLANK_CYC(BL), .BLINK_SCANS(BS), .SEG_ACT_LOW(0), .AN_ACT_LOW(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0, n_pass = 0;
  logic [7:0] gtab [38];

  // model: k = cycles of scanning since reset; banks as the rules describe
  int         k;
  logic [5:0] pc [6], ac [6];
  logic [5:0] pdp, adp, pbl, abl;
  bit         upd;
  logic [5:0] e_an;
  logic [7:0] e_seg;
  logic       e_ss;
  logic [5:0] code [6];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
  endtask

  function automatic logic [6:0] glyph(input logic [5:0] c);
    return (c < 38) ? gtab[c][6:0] : 7'h00;
  endfunction

  task automatic model_edge(input logic r, input logic ld);
    int cnt, dg, ph;
    if (r) begin
      k = 0; upd = 0;
      for (int i = 0; i < 6; i++) begin pc[i] = 6'd63; ac[i] = 6'd63; end
      pdp = '0; adp = '0; pbl = '0; abl = '0;
      e_an = '0; e_seg = '0; e_ss = 1'b0;
      return;
    end
    cnt = k % CD;
    dg  = (k / CD) % 6;
    ph  = (k / (SCAN * BS)) % 2;
    e_ss  = (k % SCAN) == 0;
    e_an  = (cnt < BL) ? 6'd0 : 6'(1 << dg);
    e_seg = 8'h00;
    if (cnt >= BL && !(abl[dg] && ph == 1)) e_seg = {adp[dg], glyph(ac[dg])};
    if ((k % SCAN) == SCAN - 1 && upd) begin
      ac = pc; adp = pdp; abl = pbl;
    end
    if ((k % SCAN) == SCAN - 1) upd = 0;
    if (ld) begin
      pc = code; pdp = bus.dp_in; pbl = bus.blink_mask; upd = 1;
    end
    k++;
  endtask

  task automatic cyc(input logic r, input logic ld);
    rst = r;
    bus.load = ld;
    {bus.Seg6, bus.Seg5, bus.Seg4, bus.Seg3, bus.Seg2, bus.Seg1} =
      {code[5], code[4], code[3], code[2], code[1], code[0]};
    @(posedge clk);
    model_edge(r, ld);
    @(negedge clk);
    chk("an", 32'(bus.an), 32'(e_an));
    chk("seg_out", 32'(bus.seg_out), 32'(e_seg));
    chk("scan_start", 32'(bus.scan_start), 32'(e_ss));
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 6; i++) code[i] = 6'($urandom_range(0, 63));
    bus.dp_in      = 6'($urandom);
    bus.blink_mask = 6'($urandom);
  endtask

  task automatic wait_to(input int t);
    for (int n = 0; n < SCAN && (k % SCAN) != t; n++) begin
      rand_inputs();
      cyc(1'b0, 1'b0);
    end
  endtask

  initial begin
    gtab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F,
             8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71, 8'h3D, 8'h76, 8'h30, 8'h1E,
             8'h75, 8'h38, 8'h37, 8'h54, 8'h5C, 8'h73, 8'h67, 8'h50, 8'h6D, 8'h78,
             8'h3E, 8'h1C, 8'h2A, 8'h76, 8'h6E, 8'h5B, 8'h40, 8'h08};
    k = 0;
    for (int i = 0; i < 6; i++) code[i] = '0;
    bus.dp_in = '0; bus.blink_mask = '0; bus.load = 1'b0; rst = 1'b1;

    repeat (3) cyc(1'b1, 1'b0);
    repeat (2 * SCAN + 3) cyc(1'b0, 1'b0);

    // known word: L S T A R -, dp on digit 3
    code = '{6'd21, 6'd28, 6'd29, 6'd10, 6'd27, 6'd36};
    bus.dp_in = 6'b001000; bus.blink_mask = '0;
    cyc(1'b0, 1'b1);
    repeat (2 * SCAN) cyc(1'b0, 1'b0);

    // load mid-scan at digit 2
    wait_to(2 * CD + 1);
    rand_inputs(); bus.blink_mask = '0;
    cyc(1'b0, 1'b1);
    repeat (2 * SCAN) cyc(1'b0, 1'b0);

    // load queued early, then a second load on the boundary edge
    wait_to(5);
    rand_inputs(); bus.blink_mask = '0;
    cyc(1'b0, 1'b1);
    wait_to(SCAN - 1);
    rand_inputs(); bus.blink_mask = '0;
    cyc(1'b0, 1'b1);
    repeat (3 * SCAN) cyc(1'b0, 1'b0);

    // blink digit 0 only
    rand_inputs(); bus.blink_mask = 6'b000001;
    cyc(1'b0, 1'b1);
    repeat (6 * SCAN) cyc(1'b0, 1'b0);

    // random traffic, including held load
    for (int n = 0; n < 700; n++) begin
      rand_inputs();
      cyc(1'b0, ($urandom_range(0, 7) == 0));
    end

    // reset mid-slot on digit 4 with a simultaneous load
    wait_to(4 * CD + 2);
    rand_inputs();
    cyc(1'b1, 1'b1);
    repeat (3 * SCAN) begin
      rand_inputs();
      cyc(1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
